// File: rtl/sprite_table_loader_if.sv
// ---- sprite_table_loader_if : sprite update write channel (valid/ready) ---- rev 1.0
`default_nettype none

interface sprite_table_loader_if;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_id;
  logic [8:0] wr_x;
  logic [8:0] wr_y;
  logic [3:0] wr_anim;
  logic       wr_flip;
  logic       wr_alt_pal;
  logic       wr_animate;
  logic [1:0] wr_frame;

  modport master (
    output wr_valid, wr_id, wr_x, wr_y, wr_anim, wr_flip, wr_alt_pal, wr_animate, wr_frame,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_id, wr_x, wr_y, wr_anim, wr_flip, wr_alt_pal, wr_animate, wr_frame,
    output wr_ready
  );
endinterface

`default_nettype wire

// File: rtl/sprite_table_loader.sv
// ---- sprite_table_loader : pending/active sprite table committed at vsync rise ---- rev 1.0
`default_nettype none

module sprite_table_loader #(
  parameter int ANIM_DIV = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        vsync,
  sprite_table_loader_if.slave        wr,
  output logic [63:0]                 sprites,
  output logic                        frame_tick
);

  localparam logic       ST_OPEN   = 1'b0;
  localparam logic       ST_COMMIT = 1'b1;
  localparam logic [7:0] DIV_LAST  = 8'(ANIM_DIV - 1);

  logic        state_q, state_d;
  logic        vsync_q, vsync_d;
  logic        ready_q, ready_d;
  logic [31:0] pend_word_q [2];
  logic [31:0] pend_word_d [2];
  logic [1:0]  pend_anim_q, pend_anim_d;
  logic [1:0]  dirty_q, dirty_d;
  logic [31:0] act_word_q [2];
  logic [31:0] act_word_d [2];
  logic [1:0]  act_anim_q, act_anim_d;
  logic [7:0]  div_q, div_d;
  logic [1:0]  anim_frame_q, anim_frame_d;
  logic [63:0] sprites_q, sprites_d;
  logic        tick_q, tick_d;

  logic        vsync_rise;
  logic        accept;
  logic [31:0] wr_word;
  logic [31:0] shown [2];

  assign vsync_rise = vsync & ~vsync_q;
  assign accept     = wr.wr_valid & ready_q & (state_q == ST_OPEN);
  // flip is stored inverted: the ppu expects bit 7 high for the unmirrored sprite
  assign wr_word    = {wr.wr_x, wr.wr_y, 6'd0, ~wr.wr_flip, wr.wr_anim, wr.wr_frame, wr.wr_alt_pal};

  assign wr.wr_ready = ready_q;
  assign sprites     = sprites_q;
  assign frame_tick  = tick_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_OPEN;
      vsync_q      <= 1'b0;
      ready_q      <= 1'b0;
      pend_word_q  <= '{default: '0};
      pend_anim_q  <= '0;
      dirty_q      <= '0;
      act_word_q   <= '{default: '0};
      act_anim_q   <= '0;
      div_q        <= '0;
      anim_frame_q <= '0;
      sprites_q    <= '0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      ready_q      <= ready_d;
      pend_word_q  <= pend_word_d;
      pend_anim_q  <= pend_anim_d;
      dirty_q      <= dirty_d;
      act_word_q   <= act_word_d;
      act_anim_q   <= act_anim_d;
      div_q        <= div_d;
      anim_frame_q <= anim_frame_d;
      sprites_q    <= sprites_d;
      tick_q       <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OPEN:   if (vsync_rise) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_OPEN;
      default:   state_d = ST_OPEN;
    endcase
  end

  always_comb begin
    vsync_d      = vsync;
    ready_d      = (state_d == ST_OPEN);
    pend_word_d  = pend_word_q;
    pend_anim_d  = pend_anim_q;
    dirty_d      = dirty_q;
    act_word_d   = act_word_q;
    act_anim_d   = act_anim_q;
    div_d        = div_q;
    anim_frame_d = anim_frame_q;
    sprites_d    = sprites_q;
    tick_d       = 1'b0;
    shown        = '{default: '0};

    if (accept) begin
      pend_word_d[wr.wr_id] = wr_word;
      pend_anim_d[wr.wr_id] = wr.wr_animate;
      dirty_d[wr.wr_id]     = 1'b1;
    end

    if (state_q == ST_COMMIT) begin
      if (div_q == DIV_LAST) begin
        div_d        = '0;
        anim_frame_d = anim_frame_q + 2'd1;
      end else begin
        div_d = div_q + 8'd1;
      end
      // clean animated sprites are refreshed too so they follow the new frame
      for (int i = 0; i < 2; i++) begin
        if (dirty_q[i]) begin
          act_word_d[i] = pend_word_q[i];
          act_anim_d[i] = pend_anim_q[i];
        end
        shown[i] = act_word_d[i];
        if (act_anim_d[i]) shown[i][2:1] = anim_frame_d;
      end
      dirty_d   = '0;
      sprites_d = {shown[0], shown[1]};
      tick_d    = 1'b1;
    end
  end

endmodule

`default_nettype wire
